fnd_scan_ctrl: RTL and testbench
================================

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 135000, meaning clocks per digit slot (blank + show); legal range BLANK_CYC+1 .. 2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 16, meaning blanked clocks at the start of each slot (ghost suppression); legal range 1 .. SCAN_DIV-1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, released synchronously by the system.
REQ-005 run  input  1  scan enable; 0 forces IDLE.
REQ-006 wr_valid  input  1  digit write request.
REQ-007 wr_ready  output  1  write accepted when wr_valid and wr_ready are both 1 on a rising edge.
REQ-008 wr_digit  input  2  target digit index 0..3.
REQ-009 wr_value  input  4  hex value 0x0..0xF.
REQ-010 wr_dp  input  1  decimal point for the target digit.
REQ-011 wr_blank  input  1  1 = target digit dark.
REQ-012 en  output  1  display driver enable, 1 while not IDLE.
REQ-013 sel  output  4  digit select, active-low, one-cold (bit i low = digit i lit), 4'b1111 = none.
REQ-014 data  output  8  {dp, g,f,e,d,c,b,a}, active-high segments.
REQ-015 digit  output  2  current slot digit index.

Function
REQ-016 Register bank SHALL hold 4 entries {value[3:0], dp, blank}, written only on an accepted write, at index wr_digit.
REQ-017 FSM SHALL have states IDLE, BLANK, SHOW, with a slot counter cnt (0..SCAN_DIV-1) and digit index register.
REQ-018 IDLE: cnt=0, digit=0; run=1 -> BLANK next edge with cnt=0.
REQ-019 BLANK: cnt+1 each edge; at cnt==BLANK_CYC-1 -> SHOW (cnt continues incrementing).
REQ-020 SHOW: cnt+1 each edge; at cnt==SCAN_DIV-1 -> BLANK, cnt=0, digit=digit+1 with wrap 3->0.
REQ-021 run=0 in BLANK or SHOW SHALL force IDLE on the next edge, with cnt=0 and digit=0; run=0 has priority over every other transition.
REQ-022 sel, data, en, digit SHALL decode only from registered state and bank, with no combinational path from any input.
REQ-023 IDLE and BLANK: sel=4'b1111, data=8'h00. SHOW: sel bit[digit]=0, others 1.
REQ-024 SHOW, entry not blank: data={dp, seg(value)}, seg hex 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-025 SHOW, entry blank=1: sel still asserted, data=8'h00.
REQ-026 wr_ready SHALL be 0 only when state==SHOW and wr_digit==digit (tear-free rule: the lit digit is never modified mid-show); otherwise 1.
REQ-027 A write accepted in the last BLANK cycle of a slot SHALL be visible in that slot's first SHOW cycle.
REQ-028 A write accepted in the same cycle run falls SHALL still update the bank.
REQ-029 Bank contents SHALL be retained across IDLE.

Reset
REQ-030 While reset=1: state=IDLE, cnt=0, digit=0, all entries value=0 / dp=0 / blank=1, sel=4'b1111, data=8'h00, en=0, wr_ready=0.
REQ-031 After reset falls: wr_ready=1 (IDLE), and scanning starts only on run=1.
REQ-032 Reset asserted mid-SHOW SHALL drive sel=4'b1111 and data=8'h00 asynchronously, without waiting for a clock edge.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-033 Reset, write digits 0..3 = 1,2,3,4 in IDLE, then run=1 -> per 8-cycle slot: 2 cycles sel=1111/data=00, then 6 cycles sel=1110 data=06, then 1101/5B, 1011/4F, 0111/66, wrap to 1110.
REQ-034 Write digit 2 value 0xA dp=1 while digit 2 is in SHOW -> wr_ready=0 until the slot's BLANK; the next digit-2 SHOW outputs data=F7.
REQ-035 Write to digit 1 in the last BLANK cycle of digit 1's slot -> accepted; first SHOW cycle shows the new value.
REQ-036 run=0 mid-SHOW on digit 3 -> next edge sel=1111, data=00, en=0, digit=0; run=1 restarts with digit 0 after BLANK_CYC cycles.
REQ-037 Reset pulse mid-SHOW -> sel=1111 and data=00 immediately; all digits blank after restart until rewritten.
REQ-038 All 16 values with dp=0/1 and blank=1 on digit 0 -> data matches the REQ-024 table with bit7=dp; blank gives data=00 with sel=1110.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl
//
// Purpose:
//   Time-multiplexed scan controller for a 4-digit, 7-segment (+dp) display.
//   It holds a 4-entry digit bank and cycles through the digits. Each digit
//   gets one slot of SCAN_DIV clocks. The first BLANK_CYC clocks of a slot
//   are dark so that the previous digit's segments do not ghost onto the next
//   digit. The remaining clocks light the digit.
//
// Parameters:
//   SCAN_DIV   clocks per digit slot, blank + show (BLANK_CYC+1 .. 2^20)
//   BLANK_CYC  dark clocks at the start of every slot (1 .. SCAN_DIV-1)
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-high; clears all state immediately
//   run       in   scan enable; 0 returns the scanner to idle
//   wr_valid  in   digit write request
//   wr_ready  out  write accepted when wr_valid && wr_ready on a rising edge
//   wr_digit  in   [1:0] target digit index
//   wr_value  in   [3:0] hex value to display
//   wr_dp     in   decimal point for the target digit
//   wr_blank  in   1 = target digit dark
//   en        out  display driver enable, high while scanning
//   sel       out  [3:0] active-low, one-cold digit select (4'b1111 = none)
//   data      out  [7:0] {dp, g, f, e, d, c, b, a}, active-high segments
//   digit     out  [1:0] digit index of the current slot
// -----------------------------------------------------------------------------
module fnd_scan_ctrl #(
  parameter int SCAN_DIV  = 135000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_dp,
  input  logic       wr_blank,
  output logic       en,
  output logic [3:0] sel,
  output logic [7:0] data,
  output logic [1:0] digit
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } entry_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       digit_q, digit_d;

  entry_t [3:0]     bank;
  entry_t           cur_entry;
  logic             show;
  logic             wr_accept;

  // ---------------------------------------------------------------------------
  // Digit bank. Each entry is its own register so the write decode per digit is
  // a plain compare against the generate index.
  // ---------------------------------------------------------------------------
  assign wr_accept = wr_valid & wr_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      entry_t entry_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q.value <= 4'h0;
          entry_q.dp    <= 1'b0;
          entry_q.blank <= 1'b1;
        end else if (wr_accept && (wr_digit == 2'(gi))) begin
          entry_q.value <= wr_value;
          entry_q.dp    <= wr_dp;
          entry_q.blank <= wr_blank;
        end
      end

      assign bank[gi] = entry_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      digit_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state. cnt runs 0..SCAN_DIV-1 across the whole slot, so the
  // BLANK -> SHOW change happens mid-count and the count simply carries on.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;

    if (!run) begin
      // Dropping run wins over every slot transition.
      state_d = ST_IDLE;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;  // wraps 3 -> 0 naturally
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Hex to segment pattern, {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Display outputs. These depend only on registers, so an asynchronous reset
  // darkens the display the moment the state registers clear.
  // ---------------------------------------------------------------------------
  assign show      = (state_q == ST_SHOW);
  assign cur_entry = bank[digit_q];
  assign en        = (state_q != ST_IDLE);
  assign digit     = digit_q;

  always_comb begin
    sel = 4'b1111;
    if (show) begin
      sel[digit_q] = 1'b0;
    end
  end

  always_comb begin
    data = 8'h00;
    if (show && !cur_entry.blank) begin
      data = {cur_entry.dp, seg7(cur_entry.value)};
    end
  end

  // The digit being lit is never rewritten mid-show. A write to it waits for
  // the next BLANK. Writes are refused while reset is held.
  assign wr_ready = ~reset & ~(show && (wr_digit == digit_q));

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_ctrl
//
// Runs fnd_scan_ctrl with SCAN_DIV=8 and BLANK_CYC=2. A reference model tracks
// how many edges have passed since scanning started, derives slot, digit and
// show/blank phase arithmetically, and keeps its own copy of the digit bank.
// The outputs are compared with the model on every falling edge. Directed
// scenarios pin the model with hand-computed literal values. A randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_fnd_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_value;
  logic       wr_dp;
  logic       wr_blank;
  logic       en;
  logic [3:0] sel;
  logic [7:0] data;
  logic [1:0] digit;

  int n_chk = 0;
  int n_bad = 0;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_digit (wr_digit),
    .wr_value (wr_value),
    .wr_dp    (wr_dp),
    .wr_blank (wr_blank),
    .en       (en),
    .sel      (sel),
    .data     (data),
    .digit    (digit)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  bit         m_act;       // scanning since run was seen high
  int         m_k;         // edges elapsed since scanning started
  logic [3:0] m_val [4];
  bit         m_dp  [4];
  bit         m_blk [4];

  function automatic int m_digit();
    return m_act ? (m_k / SD) % 4 : 0;
  endfunction

  function automatic bit m_show();
    return m_act && ((m_k % SD) >= BC);
  endfunction

  function automatic logic [3:0] exp_sel();
    logic [3:0] one;
    one = 4'b0001;
    return m_show() ? ~(one << m_digit()) : 4'b1111;
  endfunction

  function automatic logic [7:0] exp_data();
    int d;
    d = m_digit();
    if (m_show() && !m_blk[d]) return {m_dp[d], seg_tbl[m_val[d]]};
    return 8'h00;
  endfunction

  function automatic bit exp_ready();
    return !(m_show() && (int'(wr_digit) == m_digit()));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0;
      m_k   = 0;
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 4'h0;
        m_dp[i]  = 1'b0;
        m_blk[i] = 1'b1;
      end
    end else begin
      if (wr_valid && exp_ready()) begin
        m_val[wr_digit] = wr_value;
        m_dp[wr_digit]  = wr_dp;
        m_blk[wr_digit] = wr_blank;
      end
      if (!run) begin
        m_act = 1'b0;
        m_k   = 0;
      end else if (!m_act) begin
        m_act = 1'b1;
        m_k   = 0;
      end else begin
        m_k++;
      end
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("en",       8'(en),       8'(m_act));
      chk("sel",      8'(sel),      8'(exp_sel()));
      chk("data",     data,         exp_data());
      chk("digit",    8'(digit),    8'(m_digit()));
      chk("wr_ready", 8'(wr_ready), 8'(exp_ready()));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input int v, input bit dp, input bit bl);
    wr_valid = 1'b1;
    wr_digit = 2'(d);
    wr_value = 4'(v);
    wr_dp    = dp;
    wr_blank = bl;
    tick();
    wr_valid = 1'b0;
    $display("write digit=%0d value=%h dp=%0d blank=%0d", d, v, dp, bl);
  endtask

  // Advance until the model says digit d is at slot offset w (bounded).
  task automatic wait_for(input int d, input int w);
    int n;
    n = 0;
    while (!(m_act && m_digit() == d && (m_k % SD) == w) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      n_bad++;
      $display("FAIL wait_for: digit %0d offset %0d not reached", d, w);
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    run      = 1'b0;
    wr_valid = 1'b0;
    wr_digit = 2'd0;
    wr_value = 4'h0;
    wr_dp    = 1'b0;
    wr_blank = 1'b0;

    // Reset state
    #1;
    chk("rst_sel",   8'(sel),      8'h0F);
    chk("rst_data",  data,         8'h00);
    chk("rst_en",    8'(en),       8'h00);
    chk("rst_ready", 8'(wr_ready), 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 8'(wr_ready), 8'h01);
    $display("reset released");

    // Basic scan of 1,2,3,4
    for (int i = 0; i < 4; i++) wr(i, i + 1, 1'b0, 1'b0);
    run = 1'b1;
    tick();
    chk("scan_blank_sel",  8'(sel), 8'h0F);
    chk("scan_blank_data", data,    8'h00);
    tick();
    tick();
    chk("scan_d0_sel",  8'(sel), 8'h0E);
    chk("scan_d0_data", data,    8'h06);
    repeat (SD) tick();
    chk("scan_d1_sel",  8'(sel), 8'h0D);
    chk("scan_d1_data", data,    8'h5B);
    repeat (SD) tick();
    chk("scan_d2_sel",  8'(sel), 8'h0B);
    chk("scan_d2_data", data,    8'h4F);
    repeat (SD) tick();
    chk("scan_d3_sel",  8'(sel), 8'h07);
    chk("scan_d3_data", data,    8'h66);
    repeat (SD) tick();
    chk("scan_wrap_sel",  8'(sel), 8'h0E);
    chk("scan_wrap_data", data,    8'h06);
    $display("basic scan done");

    // Tear-free write to the lit digit
    wait_for(2, BC);
    wr_valid = 1'b1;
    wr_digit = 2'd2;
    wr_value = 4'hA;
    wr_dp    = 1'b1;
    wr_blank = 1'b0;
    #1;
    chk("tear_ready_low", 8'(wr_ready), 8'h00);
    n = 0;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    chk("tear_wait_bounded", 8'(n < 20), 8'h01);
    chk("tear_accept_in_blank", 8'(sel), 8'h0F);
    tick();
    wr_valid = 1'b0;
    wait_for(2, BC);
    chk("tear_new_data", data, 8'hF7);
    $display("tear-free write done");

    // Write in the last BLANK cycle is visible in the first SHOW cycle
    wait_for(1, BC - 1);
    wr_valid = 1'b1;
    wr_digit = 2'd1;
    wr_value = 4'h9;
    wr_dp    = 1'b0;
    wr_blank = 1'b0;
    #1;
    chk("lastblank_ready", 8'(wr_ready), 8'h01);
    tick();
    wr_valid = 1'b0;
    chk("lastblank_sel",  8'(sel), 8'h0D);
    chk("lastblank_data", data,    8'h6F);
    $display("last-blank write done");

    // run=0 mid-show on digit 3
    wait_for(3, BC + 1);
    run = 1'b0;
    tick();
    chk("stop_sel",   8'(sel),   8'h0F);
    chk("stop_data",  data,      8'h00);
    chk("stop_en",    8'(en),    8'h00);
    chk("stop_digit", 8'(digit), 8'h00);
    run = 1'b1;
    repeat (BC) tick();
    chk("restart_blank_sel", 8'(sel), 8'h0F);
    tick();
    chk("restart_sel",   8'(sel),   8'h0E);
    chk("restart_digit", 8'(digit), 8'h00);
    $display("stop/restart done");

    // Asynchronous reset mid-show
    wait_for(1, BC + 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_sel",   8'(sel),      8'h0F);
    chk("async_rst_data",  data,         8'h00);
    chk("async_rst_en",    8'(en),       8'h00);
    chk("async_rst_ready", 8'(wr_ready), 8'h00);
    tick();
    reset = 1'b0;
    run   = 1'b0;
    tick();
    run = 1'b1;
    wait_for(0, BC);
    chk("rst_blank_d0_sel",  8'(sel), 8'h0E);
    chk("rst_blank_d0_data", data,    8'h00);
    wait_for(2, BC);
    chk("rst_blank_d2_data", data, 8'h00);
    $display("async reset done");

    // All values with dp on digit 0
    run = 1'b0;
    tick();
    for (int v = 0; v < 16; v++) begin
      for (int d = 0; d < 2; d++) begin
        wr(0, v, d[0], 1'b0);
        run = 1'b1;
        repeat (BC + 1) tick();
        chk("table_data", data, {d[0], seg_tbl[v]});
        run = 1'b0;
        tick();
      end
    end
    wr(0, 5, 1'b1, 1'b1);
    run = 1'b1;
    repeat (BC + 1) tick();
    chk("table_blank_sel",  8'(sel), 8'h0E);
    chk("table_blank_data", data,    8'h00);
    $display("segment table done");

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      run      = ($urandom_range(0, 39) != 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_digit = 2'($urandom_range(0, 3));
      wr_value = 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      wr_blank = ($urandom_range(0, 7) == 0);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    $display("random phase done");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
